// File: rtl/ray_math_pkg.sv
// Shared fixed-point types and constants for the ray-math datapath.
package ray_math_pkg;

  localparam int unsigned FX_WIDTH = 32;
  localparam int unsigned FX_QBITS = 10;

  typedef logic signed [FX_WIDTH-1:0] fx_t;

  localparam fx_t FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};

endpackage

// File: rtl/vec_scale_lane.sv
// Single-lane round/shift/saturate of a full-width product back to DATA_WIDTH.
module vec_scale_lane
  import ray_math_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FX_WIDTH,
  parameter int unsigned Q_BITS     = FX_QBITS
) (
  input  logic signed [2*DATA_WIDTH-1:0] product,
  input  logic                           round_en,
  input  logic                           sat_en,
  output logic        [DATA_WIDTH-1:0]   res,
  output logic                           ovf
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  // Half an LSB of the result; evaluates to zero when Q_BITS is 0.
  localparam logic signed [PW-1:0] RND_HALF = PW'((PW'(1) << Q_BITS) >> 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]            rnd_add;
  logic signed [PW-1:0]            sum;
  logic signed [PW-1:0]            shifted;
  logic        [PW-DATA_WIDTH:0]   hi_bits;

  // Round, arithmetic shift, then detect overflow and clamp or wrap.
  always_comb begin
    rnd_add = '0;
    if (round_en) begin
      rnd_add = RND_HALF;
    end
    sum     = product + rnd_add;
    shifted = sum >>> Q_BITS;
    // Result fits only if every bit above the target sign bit matches it.
    hi_bits = shifted[PW-1:DATA_WIDTH-1];
    ovf     = !((&hi_bits) || !(|hi_bits));
    res     = shifted[DATA_WIDTH-1:0];
    if (sat_en && ovf) begin
      res = shifted[PW-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/vec_scale_pipe.sv
// Two-stage FIFO-to-FIFO fixed-point vector scaler with overflow tracking.
module vec_scale_pipe
  import ray_math_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FX_WIDTH,
  parameter int unsigned Q_BITS     = FX_QBITS,
  parameter int unsigned N_LANES    = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_LANES-1:0][DATA_WIDTH-1:0]   x,
  input  logic [DATA_WIDTH-1:0]                a,
  input  logic                                 round_en,
  input  logic                                 sat_en,
  input  logic                                 in_empty,
  output logic                                 in_rd_en,
  output logic [N_LANES-1:0][DATA_WIDTH-1:0]   out,
  output logic [N_LANES-1:0]                   out_ovf,
  input  logic                                 out_full,
  output logic                                 out_wr_en,
  input  logic                                 ovf_clr,
  output logic [CNT_WIDTH-1:0]                 ovf_count
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                                 v1_q;
  logic                                 v2_q;
  logic                                 rnd_q;
  logic                                 sat_q;
  logic signed [PW-1:0]                 prod_d [N_LANES];
  logic signed [PW-1:0]                 prod_q [N_LANES];
  logic [N_LANES-1:0][DATA_WIDTH-1:0]   res_c;
  logic [N_LANES-1:0]                   ovf_c;
  logic [N_LANES-1:0][DATA_WIDTH-1:0]   out_q;
  logic [N_LANES-1:0]                   ovf_q;
  logic [CNT_WIDTH-1:0]                 cnt_q;
  logic                                 stall;

  // Output stage blocked by a full downstream FIFO freezes the whole pipe.
  assign stall     = v2_q & out_full;
  assign in_rd_en  = !reset & !in_empty & !stall;
  assign out_wr_en = v2_q & !out_full;
  assign out       = out_q;
  assign out_ovf   = ovf_q;
  assign ovf_count = cnt_q;

  // Full-precision signed products of each lane with the shared scalar.
  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      prod_d[i] = PW'($signed(x[i])) * PW'($signed(a));
    end
  end

  // Per-lane round/shift/saturate on the S1 products.
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    vec_scale_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .Q_BITS     (Q_BITS)
    ) u_lane (
      .product  (prod_q[g]),
      .round_en (rnd_q),
      .sat_en   (sat_q),
      .res      (res_c[g]),
      .ovf      (ovf_c[g])
    );
  end

  // S1 captures products and mode bits on a pop; S2 registers the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      rnd_q <= 1'b0;
      sat_q <= 1'b0;
      out_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        prod_q[i] <= '0;
      end
    end else if (!stall) begin
      v1_q <= in_rd_en;
      if (in_rd_en) begin
        rnd_q <= round_en;
        sat_q <= sat_en;
        for (int i = 0; i < N_LANES; i++) begin
          prod_q[i] <= prod_d[i];
        end
      end
      v2_q <= v1_q;
      if (v1_q) begin
        out_q <= res_c;
        ovf_q <= ovf_c;
      end
    end
  end

  // Saturating count of written vectors carrying any overflowed lane.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (ovf_clr) begin
      cnt_q <= '0;
    end else if (out_wr_en && (|ovf_q) && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_vec_scale_pipe.sv
// Directed bench for vec_scale_pipe (DATA_WIDTH=32, Q_BITS=10, N_LANES=3).
module tb_vec_scale_pipe;

  logic              clock;
  logic              reset;
  logic [2:0][31:0]  x;
  logic [31:0]       a;
  logic              round_en;
  logic              sat_en;
  logic              in_empty;
  logic              in_rd_en;
  logic [2:0][31:0]  out;
  logic [2:0]        out_ovf;
  logic              out_full;
  logic              out_wr_en;
  logic              ovf_clr;
  logic [15:0]       ovf_count;

  int n_checks = 0;
  int n_fail   = 0;

  vec_scale_pipe #(
    .DATA_WIDTH (32),
    .Q_BITS     (10),
    .N_LANES    (3),
    .CNT_WIDTH  (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .a         (a),
    .round_en  (round_en),
    .sat_en    (sat_en),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out       (out),
    .out_ovf   (out_ovf),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pop one vector and check latency plus the written result.
  task automatic run_vec(input string tag,
                         input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [31:0] av, input logic rnd, input logic sat,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [2:0] eovf);
    x[0] = x0; x[1] = x1; x[2] = x2;
    a = av; round_en = rnd; sat_en = sat;
    in_empty = 1'b0;
    #1;
    check({tag, "_rd"}, 64'(in_rd_en), 64'd1);
    @(posedge clock); #1;
    in_empty = 1'b1;
    #1;
    check({tag, "_wr_t1"}, 64'(out_wr_en), 64'd0);
    @(posedge clock); #2;
    check({tag, "_wr_t2"}, 64'(out_wr_en), 64'd1);
    check({tag, "_l0"}, 64'(out[0]), 64'(e0));
    check({tag, "_l1"}, 64'(out[1]), 64'(e1));
    check({tag, "_l2"}, 64'(out[2]), 64'(e2));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(eovf));
    @(posedge clock); #1;
  endtask

  logic [31:0] sx [8][3];
  logic        v1m, v2m, stall_m, rd_m, wr_m;
  int          sent, recv, cyc;

  initial begin
    reset = 1'b1; x = '0; a = '0; round_en = 1'b0; sat_en = 1'b0;
    in_empty = 1'b0; out_full = 1'b0; ovf_clr = 1'b0;
    #12;
    check("rst_rd", 64'(in_rd_en), 64'd0);
    check("rst_wr", 64'(out_wr_en), 64'd0);
    check("rst_out", 64'(out[0] | out[1] | out[2]), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    check("rst_cnt", 64'(ovf_count), 64'd0);
    in_empty = 1'b1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Basic scaling.
    run_vec("t1", 32'd2048, -32'sd3072, 32'd512, 32'd1536, 1'b0, 1'b1,
            32'd3072, -32'sd4608, 32'd768, 3'b000);
    // Truncate vs round half up.
    run_vec("t2trunc", 32'd1, -32'sd1, -32'sd2, 32'd512, 1'b0, 1'b1,
            32'd0, -32'sd1, -32'sd1, 3'b000);
    run_vec("t2rnd", 32'd1, -32'sd1, -32'sd2, 32'd512, 1'b1, 1'b1,
            32'd1, 32'd0, -32'sd1, 3'b000);
    // Saturate vs wrap on overflow.
    run_vec("t3sat", 32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd2048, 1'b0, 1'b1,
            32'h7FFFFFFF, 32'h80000000, 32'd10, 3'b011);
    #1 check("t3_cnt1", 64'(ovf_count), 64'd1);
    run_vec("t3wrap", 32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd2048, 1'b0, 1'b0,
            32'hFFFFFFFE, 32'h00000000, 32'd10, 3'b011);
    #1 check("t3_cnt2", 64'(ovf_count), 64'd2);

    // Stream 8 vectors at unity scale with a 5-cycle downstream stall.
    for (int k = 0; k < 8; k++) begin
      sx[k][0] = 32'(100 + k);
      sx[k][1] = 32'(-(200 + k));
      sx[k][2] = 32'(300 * k);
    end
    a = 32'd1024; round_en = 1'b0; sat_en = 1'b1;
    v1m = 1'b0; v2m = 1'b0; sent = 0; recv = 0; cyc = 0;
    @(posedge clock); #1;
    while (recv < 8 && cyc < 60) begin
      out_full = (cyc >= 3 && cyc < 8);
      in_empty = (sent >= 8);
      if (sent < 8) begin
        x[0] = sx[sent][0]; x[1] = sx[sent][1]; x[2] = sx[sent][2];
      end
      #1;
      stall_m = v2m & out_full;
      rd_m    = !in_empty & !stall_m;
      wr_m    = v2m & !out_full;
      check("t4_rd", 64'(in_rd_en), 64'(rd_m));
      check("t4_wr", 64'(out_wr_en), 64'(wr_m));
      if (wr_m) begin
        check("t4_l0", 64'(out[0]), 64'(sx[recv][0]));
        check("t4_l1", 64'(out[1]), 64'(sx[recv][1]));
        check("t4_l2", 64'(out[2]), 64'(sx[recv][2]));
        recv++;
      end
      if (!stall_m) begin
        v2m = v1m;
        v1m = rd_m;
        if (rd_m) sent++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    check("t4_all_written", 64'(recv), 64'd8);
    out_full = 1'b0; in_empty = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Reset with two vectors held in flight behind a full downstream FIFO.
    out_full = 1'b1;
    x[0] = 32'd7; x[1] = 32'd8; x[2] = 32'd9; a = 32'd1024;
    in_empty = 1'b0;
    @(posedge clock); #1;
    x[0] = 32'd10;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("t5_rd_in_rst", 64'(in_rd_en), 64'd0);
    check("t5_wr_in_rst", 64'(out_wr_en), 64'd0);
    check("t5_out_rst", 64'(out[0] | out[1] | out[2]), 64'd0);
    check("t5_cnt_rst", 64'(ovf_count), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0; in_empty = 1'b1; out_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("t5_no_wr", 64'(out_wr_en), 64'd0);
      @(posedge clock); #1;
    end
    run_vec("t5_after", 32'd3000, -32'sd4000, 32'd1, 32'd3072, 1'b0, 1'b1,
            32'd9000, -32'sd12000, 32'd3, 3'b000);

    // Saturate the overflow counter, then clear it during an overflowing write.
    x[0] = 32'h7FFFFFFF; x[1] = 32'h80000000; x[2] = 32'd5; a = 32'd2048;
    round_en = 1'b0; sat_en = 1'b1; in_empty = 1'b0;
    cyc = 0;
    while (ovf_count != 16'hFFFF && cyc < 70000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("t6_cnt_reach", 64'(ovf_count), 64'hFFFF);
    repeat (5) @(posedge clock);
    #1;
    check("t6_cnt_hold", 64'(ovf_count), 64'hFFFF);
    ovf_clr = 1'b1; in_empty = 1'b1;
    #1;
    check("t6_clr_wr", 64'(out_wr_en), 64'd1);
    check("t6_clr_ovf", 64'(out_ovf), 64'b011);
    @(posedge clock); #1;
    ovf_clr = 1'b0;
    check("t6_cnt_clr", 64'(ovf_count), 64'd0);
    @(posedge clock); #1;
    check("t6_cnt_after", 64'(ovf_count), 64'd1);
    check("t6_drained", 64'(out_wr_en), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
